// File: rtl/alu_pkg.sv
// Shared types for the 8-bit ALU and its fetch/decode/execute sequencer.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD        = 3'd0,
    SUBTRACT   = 3'd1,
    BIT_AND    = 3'd2,
    BIT_OR     = 3'd3,
    BIT_XOR    = 3'd4,
    BIT_NOT    = 3'd5,
    LOAD_B     = 3'd6,
    LOAD_B_ALT = 3'd7
  } instruction_code;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPERAND,
    S_EXEC,
    S_HALTED
  } seq_state_t;

  localparam logic [1:0] CLS_ALU_IMM = 2'b00;
  localparam logic [1:0] CLS_ALU_REG = 2'b01;
  localparam logic [1:0] CLS_STORE   = 2'b10;
  localparam logic [1:0] CLS_SPECIAL = 2'b11;

  localparam logic [2:0] SP_NOP  = 3'b000;
  localparam logic [2:0] SP_HALT = 3'b001;
  localparam logic [2:0] SP_JMP  = 3'b010;
  localparam logic [2:0] SP_JC   = 3'b011;

  // Instructions carrying a second (immediate/target) byte in program memory.
  function automatic logic is_two_byte(logic [7:0] instr);
    logic [1:0] cls;
    logic [2:0] sub;
    cls = instr[4:3];
    sub = instr[2:0];
    return (cls == CLS_ALU_IMM) ||
           ((cls == CLS_SPECIAL) && ((sub == SP_JMP) || (sub == SP_JC)));
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of program-memory, register-file and ALU signals around the sequencer.
interface alu_sequencer_if;
  import alu_pkg::*;

  logic            i_start;
  logic            o_busy;
  logic            o_halted;
  logic [7:0]      o_pmem_addr;
  logic            o_pmem_re;
  logic [7:0]      i_pmem_data;
  logic [2:0]      o_rf_addr;
  logic [7:0]      i_rf_data;
  logic            o_rf_we;
  logic [7:0]      o_rf_wdata;
  instruction_code o_alu_op;
  logic            o_alu_ce;
  logic            o_alu_carry_we;
  logic [7:0]      o_alu_a;
  logic [7:0]      o_alu_b;
  logic [7:0]      i_alu_result;
  logic            i_alu_carry;
  logic [7:0]      o_acc;
  logic            o_carry;

  modport master (
    input  i_start, i_pmem_data, i_rf_data, i_alu_result, i_alu_carry,
    output o_busy, o_halted, o_pmem_addr, o_pmem_re, o_rf_addr, o_rf_we,
           o_rf_wdata, o_alu_op, o_alu_ce, o_alu_carry_we, o_alu_a, o_alu_b,
           o_acc, o_carry
  );

  modport slave (
    output i_start, i_pmem_data, i_rf_data, i_alu_result, i_alu_carry,
    input  o_busy, o_halted, o_pmem_addr, o_pmem_re, o_rf_addr, o_rf_we,
           o_rf_wdata, o_alu_op, o_alu_ce, o_alu_carry_we, o_alu_a, o_alu_b,
           o_acc, o_carry
  );

endinterface

// File: rtl/alu_sequencer_decode.sv
// Combinational decode of one instruction byte into class and control flags.
module seq_decode
  import alu_pkg::*;
(
  input  logic [7:0] instr_i,
  output logic [1:0] cls_o,
  output logic       two_byte_o,
  output logic       store_o,
  output logic       halt_o,
  output logic       jmp_o,
  output logic       jc_o,
  output logic       carry_we_o
);

  logic [2:0] sub;
  logic       special;
  logic       alu_class;

  assign cls_o      = instr_i[4:3];
  assign sub        = instr_i[2:0];
  assign special    = (cls_o == CLS_SPECIAL);
  assign alu_class  = (cls_o == CLS_ALU_IMM) || (cls_o == CLS_ALU_REG);

  assign two_byte_o = is_two_byte(instr_i);
  assign store_o    = (cls_o == CLS_STORE);
  assign halt_o     = special && (sub == SP_HALT);
  assign jmp_o      = special && (sub == SP_JMP);
  assign jc_o       = special && (sub == SP_JC);
  // Only ADD owns the carry flag; every other op leaves it alone.
  assign carry_we_o = alu_class && (instruction_code'(instr_i[7:5]) == ADD);

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller: owns PC, IR, ACC and carry and sequences the ALU.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.master bus
);

  seq_state_t state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] acc_q, acc_d;
  logic       carry_q, carry_d;

  logic       pmem_re;
  logic       rf_we;
  logic       alu_ce;
  logic       carry_we;
  logic [7:0] alu_b;

  logic [7:0] dec_in;
  logic [1:0] dec_cls;
  logic       dec_two_byte;
  logic       dec_store;
  logic       dec_halt;
  logic       dec_jmp;
  logic       dec_jc;
  logic       dec_carry_we;
  logic       dec_is_alu;

  // DECODE looks at the byte arriving from memory; EXEC looks at the latched IR.
  assign dec_in = (state_q == S_DECODE) ? bus.i_pmem_data : ir_q;

  seq_decode u_decode (
    .instr_i    (dec_in),
    .cls_o      (dec_cls),
    .two_byte_o (dec_two_byte),
    .store_o    (dec_store),
    .halt_o     (dec_halt),
    .jmp_o      (dec_jmp),
    .jc_o       (dec_jc),
    .carry_we_o (dec_carry_we)
  );

  assign dec_is_alu = (dec_cls == CLS_ALU_IMM) || (dec_cls == CLS_ALU_REG);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    pmem_re  = 1'b0;
    rf_we    = 1'b0;
    alu_ce   = 1'b0;
    carry_we = 1'b0;
    alu_b    = 8'h00;

    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (bus.i_start) begin
          pc_d    = 8'h00;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        pmem_re = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = bus.i_pmem_data;
        pc_d    = pc_q + 8'd1;
        state_d = dec_two_byte ? S_OPERAND : S_EXEC;
      end
      S_OPERAND: begin
        pmem_re = 1'b1;
        pc_d    = pc_q + 8'd1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // A reset landing on EXEC must not leak a register-file write.
        alu_b   = dec_two_byte ? bus.i_pmem_data : bus.i_rf_data;
        state_d = dec_halt ? S_HALTED : S_FETCH;
        rf_we   = dec_store && !rst;
        if (dec_is_alu) begin
          alu_ce = !rst;
          acc_d  = bus.i_alu_result;
        end
        if (dec_carry_we) begin
          carry_we = !rst;
          carry_d  = bus.i_alu_carry;
        end
        if (dec_jmp || (dec_jc && carry_q)) begin
          pc_d = bus.i_pmem_data;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
      acc_q   <= 8'h00;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign bus.o_busy         = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign bus.o_halted       = (state_q == S_HALTED);
  assign bus.o_pmem_addr    = pc_q;
  assign bus.o_pmem_re      = pmem_re;
  assign bus.o_rf_addr      = ir_q[2:0];
  assign bus.o_rf_we        = rf_we;
  assign bus.o_rf_wdata     = acc_q;
  assign bus.o_alu_op       = instruction_code'(ir_q[7:5]);
  assign bus.o_alu_ce       = alu_ce;
  assign bus.o_alu_carry_we = carry_we;
  assign bus.o_alu_a        = acc_q;
  assign bus.o_alu_b        = alu_b;
  assign bus.o_acc          = acc_q;
  assign bus.o_carry        = carry_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with behavioural program memory, register file and ALU.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [256];
  logic [7:0] rf [8];
  logic [8:0] aluWide;

  int vectorsApplied = 0;
  int miscompares    = 0;
  int carryWeCount   = 0;
  int rfWeCount      = 0;
  int fetchZeroCount = 0;
  logic [2:0] lastRfAddr = 3'd0;
  logic [7:0] lastRfData = 8'h00;

  always @(posedge clk) begin
    if (bus.o_pmem_re) bus.i_pmem_data <= mem[bus.o_pmem_addr];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) rf[k] <= 8'h00;
    end else if (bus.o_rf_we) begin
      rf[bus.o_rf_addr] <= bus.o_rf_wdata;
    end
  end
  assign bus.i_rf_data = rf[bus.o_rf_addr];

  // ALU reference; SUBTRACT reports borrow so a wrongly committed carry is visible.
  always_comb begin
    aluWide = 9'd0;
    case (bus.o_alu_op)
      ADD:      aluWide = {1'b0, bus.o_alu_a} + {1'b0, bus.o_alu_b};
      SUBTRACT: aluWide = {1'b0, bus.o_alu_a} - {1'b0, bus.o_alu_b};
      BIT_AND:  aluWide = {1'b0, bus.o_alu_a & bus.o_alu_b};
      BIT_OR:   aluWide = {1'b0, bus.o_alu_a | bus.o_alu_b};
      BIT_XOR:  aluWide = {1'b0, bus.o_alu_a ^ bus.o_alu_b};
      BIT_NOT:  aluWide = {1'b0, ~bus.o_alu_a};
      default:  aluWide = {1'b0, bus.o_alu_b};
    endcase
  end
  assign bus.i_alu_result = aluWide[7:0];
  assign bus.i_alu_carry  = aluWide[8];

  always @(negedge clk) begin
    if (bus.o_alu_carry_we) carryWeCount <= carryWeCount + 1;
    if (bus.o_rf_we) begin
      rfWeCount  <= rfWeCount + 1;
      lastRfAddr <= bus.o_rf_addr;
      lastRfData <= bus.o_rf_wdata;
    end
    if (bus.o_pmem_re && (bus.o_pmem_addr == 8'h00)) fetchZeroCount <= fetchZeroCount + 1;
  end

  typedef struct {
    string      name;
    logic [95:0] prog;
    int         len;
    logic [7:0] patchAddr;
    logic [7:0] patchData;
    logic [7:0] expAcc;
    logic       expCarry;
    logic [7:0] expPc;
    int         expCycles;
    int         expCarryWe;
    int         expRfWe;
    logic [2:0] expRfAddr;
    logic [7:0] expRfData;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    bus.i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic fillMemory();
    for (int a = 0; a < 256; a++) mem[a] = 8'h19;
  endtask

  task automatic startPulse();
    bus.i_start = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
  endtask

  task automatic waitHalt(input int startCount, output int cycles);
    cycles = startCount;
    while (!bus.o_halted && cycles < 400) begin
      @(posedge clk);
      #1 cycles++;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int cycles;
    int cwBase;
    int rfBase;
    resetDut();
    fillMemory();
    for (int i = 0; i < v.len; i++) mem[i] = v.prog[95 - 8*i -: 8];
    mem[v.patchAddr] = v.patchData;
    cwBase = carryWeCount;
    rfBase = rfWeCount;
    startPulse();
    waitHalt(1, cycles);
    checkOutput({v.name, "_halted"}, 64'(bus.o_halted), 64'd1);
    checkOutput({v.name, "_cycles"}, 64'(cycles), 64'(v.expCycles));
    checkOutput({v.name, "_acc"}, 64'(bus.o_acc), 64'(v.expAcc));
    checkOutput({v.name, "_carry"}, 64'(bus.o_carry), 64'(v.expCarry));
    checkOutput({v.name, "_pc"}, 64'(bus.o_pmem_addr), 64'(v.expPc));
    checkOutput({v.name, "_carry_we"}, 64'(carryWeCount - cwBase), 64'(v.expCarryWe));
    checkOutput({v.name, "_rf_we"}, 64'(rfWeCount - rfBase), 64'(v.expRfWe));
    if (v.expRfWe != 0) begin
      checkOutput({v.name, "_rf_addr"}, 64'(lastRfAddr), 64'(v.expRfAddr));
      checkOutput({v.name, "_rf_data"}, 64'(lastRfData), 64'(v.expRfData));
    end
  endtask

  function automatic logic [63:0] allOutputs();
    return 64'({bus.o_busy, bus.o_halted, bus.o_pmem_addr, bus.o_pmem_re, bus.o_rf_addr,
                bus.o_rf_we, bus.o_rf_wdata, bus.o_alu_op, bus.o_alu_ce, bus.o_alu_carry_we,
                bus.o_alu_a, bus.o_alu_b, bus.o_acc, bus.o_carry});
  endfunction

  initial begin
    int cycles;
    int base;

    vecs[0] = '{"load_imm",  {24'hC07F19, 72'd0},               3, 8'hF0, 8'h19, 8'h7F, 1'b0, 8'h03,  8, 0, 0, 3'd0, 8'h00};
    vecs[1] = '{"add_carry", {40'hC07F008119, 56'd0},           5, 8'hF0, 8'h19, 8'h00, 1'b1, 8'h05, 12, 1, 0, 3'd0, 8'h00};
    vecs[2] = '{"store_xor", {56'hC05A15C0FF8D19, 40'd0},       7, 8'hF0, 8'h19, 8'hA5, 1'b0, 8'h07, 18, 0, 1, 3'd5, 8'h5A};
    vecs[3] = '{"jc_taken",  {72'hC07F00811B10C01119, 24'd0},   9, 8'hF0, 8'h19, 8'h00, 1'b1, 8'h11, 16, 1, 0, 3'd0, 8'h00};
    vecs[4] = '{"jc_fall",   {72'hC07F00011B10C01119, 24'd0},   9, 8'hF0, 8'h19, 8'h11, 1'b0, 8'h09, 20, 1, 0, 3'd0, 8'h00};
    vecs[5] = '{"jmp_nop",   {40'h1A05C03319, 56'd0},           5, 8'h05, 8'h18, 8'h00, 1'b0, 8'h07, 11, 0, 0, 3'd0, 8'h00};
    vecs[6] = '{"logic_ops", 96'hC0FF00012000A8400F603019,     12, 8'hF0, 8'h19, 8'h3F, 1'b1, 8'h0C, 27, 1, 0, 3'd0, 8'h00};
    vecs[7] = '{"pc_wrap",   {16'h1AFF, 80'd0},                 2, 8'hFF, 8'hC0, 8'h1A, 1'b0, 8'h03, 15, 0, 0, 3'd0, 8'h00};

    bus.i_start = 1'b0;
    fillMemory();
    resetDut();
    checkOutput("reset_outputs", allOutputs(), 64'd0);

    for (int n = 0; n < 8; n++) applyStimulus(vecs[n]);

    // JMP 0x00 keeps the machine busy, refetching address 0 every 4 cycles.
    resetDut();
    fillMemory();
    mem[0] = 8'h1A;
    mem[1] = 8'h00;
    base = fetchZeroCount;
    startPulse();
    repeat (24) @(posedge clk);
    #1;
    checkOutput("jmp_loop_busy", 64'({bus.o_busy, bus.o_halted}), 64'b10);
    checkOutput("jmp_loop_fetches", 64'(fetchZeroCount - base), 64'd6);

    // Reset arriving during the EXEC of STORE r5.
    resetDut();
    fillMemory();
    mem[0] = 8'hC0; mem[1] = 8'h5A; mem[2] = 8'h15;
    startPulse();
    repeat (6) @(posedge clk);
    #1;
    checkOutput("rst_exec_ir", 64'({bus.o_rf_addr, bus.o_acc}), 64'({3'd5, 8'h5A}));
    base = rfWeCount;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_exec_rf_we", 64'(rfWeCount - base), 64'd0);
    checkOutput("rst_exec_rf5", 64'(rf[5]), 64'd0);
    checkOutput("rst_exec_outputs", allOutputs(), 64'd0);
    rst = 1'b0;

    // Start pulsed during the FETCH at PC=2 must not rewind the PC.
    resetDut();
    fillMemory();
    mem[0] = 8'hC0; mem[1] = 8'h11; mem[2] = 8'h19;
    startPulse();
    repeat (4) @(posedge clk);
    #1;
    checkOutput("busy_fetch_addr", 64'({bus.o_pmem_re, bus.o_pmem_addr}), 64'({1'b1, 8'h02}));
    startPulse();
    waitHalt(6, cycles);
    checkOutput("busy_start_cycles", 64'(cycles), 64'd8);
    checkOutput("busy_start_pc", 64'(bus.o_pmem_addr), 64'h03);
    checkOutput("busy_start_acc", 64'(bus.o_acc), 64'h11);

    // Restart from HALTED keeps ACC and carry.
    resetDut();
    fillMemory();
    mem[0] = 8'h00; mem[1] = 8'h90;
    startPulse();
    waitHalt(1, cycles);
    checkOutput("restart_first", 64'({bus.o_halted, bus.o_acc, bus.o_carry}), 64'({1'b1, 8'h90, 1'b0}));
    startPulse();
    checkOutput("restart_refetch", 64'({bus.o_pmem_re, bus.o_pmem_addr, bus.o_acc}), 64'({1'b1, 8'h00, 8'h90}));
    waitHalt(1, cycles);
    checkOutput("restart_cycles", 64'(cycles), 64'd8);
    checkOutput("restart_second", 64'({bus.o_acc, bus.o_carry}), 64'({8'h20, 1'b1}));
    mem[0] = 8'h20; mem[1] = 8'h00;
    startPulse();
    waitHalt(1, cycles);
    checkOutput("restart_sub_keeps_carry", 64'({bus.o_halted, bus.o_acc, bus.o_carry}), 64'({1'b1, 8'h20, 1'b1}));

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
